// File: rtl/eth_tx_pad.sv
// eth_tx_pad: buffers one payload, sends it zero-padded to MIN_LEN bytes, then holds an inter-frame gap
`timescale 1ns/1ps
module eth_tx_pad #(
    parameter int MIN_LEN    = 46,
    parameter int MAX_LEN    = 1024,
    parameter int GAP_CYCLES = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_wdata,
    input  logic        i_wvalid,
    input  logic        i_wlast,
    output logic        o_wready,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic        o_tlast,
    output logic        o_trunc,
    output logic [15:0] o_frame_cnt
);
    localparam int NW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    typedef enum logic [1:0] {FILL, SEND, PAD, GAP} state_t;
    state_t state, state_nx;
    logic [7:0] mem [MAX_LEN];
    logic [7:0] rdata;
    logic [NW-1:0] n, idx, len;
    logic [AW-1:0] raddr;
    logic [GW-1:0] gcnt;
    logic primed, acc, full, close, ld, done;
    assign acc   = state == FILL && i_wvalid && o_wready;
    assign full  = n == NW'(MAX_LEN - 1);
    assign close = acc && (i_wlast || full);
    assign len   = n < NW'(MIN_LEN) ? NW'(MIN_LEN) : n;
    // primed covers the first read-latency cycle, so the first load sees buffer[0]
    assign ld    = (state == SEND || state == PAD) && primed && idx < len && (!o_tvalid || i_tready);
    assign done  = o_tvalid && o_tlast && i_tready;
    // read one ahead when loading so rdata always holds the byte at idx
    assign raddr = AW'(idx + NW'(ld));
    always_comb begin
        state_nx = state;
        case (state)
            FILL: state_nx = close ? SEND : FILL;
            SEND: state_nx = done ? GAP : (ld && idx == n - NW'(1) && n < NW'(MIN_LEN)) ? PAD : SEND;
            PAD:  state_nx = done ? GAP : PAD;
            GAP:  state_nx = gcnt == GW'(GAP_CYCLES - 1) ? FILL : GAP;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FILL;
        else          state <= state_nx;
    end
    always_ff @(posedge i_clk) begin
        if (acc) mem[n[AW-1:0]] <= i_wdata;
        rdata <= mem[raddr];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            n           <= '0;
            idx         <= '0;
            gcnt        <= '0;
            primed      <= 1'b0;
            o_wready    <= 1'b0;
            o_tdata     <= 8'h00;
            o_tvalid    <= 1'b0;
            o_tlast     <= 1'b0;
            o_trunc     <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_wready <= state_nx == FILL;
            o_trunc  <= acc && full && !i_wlast;
            primed   <= state == SEND || state == PAD;
            idx      <= state == FILL ? '0 : idx + NW'(ld);
            gcnt     <= state == GAP ? gcnt + GW'(1) : '0;
            if (acc) n <= n + NW'(1);
            else if (state == GAP && state_nx == FILL) n <= '0;
            if (ld) begin
                o_tdata  <= idx < n ? rdata : 8'h00;
                o_tvalid <= 1'b1;
                o_tlast  <= idx == len - NW'(1);
            end else if (i_tready) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
            end
            if (done) o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_eth_tx_pad.sv
// tb_eth_tx_pad: directed checks of padding, backpressure, truncation, gap and reset behaviour
`timescale 1ns/1ps
module tb_eth_tx_pad;
    logic i_clk = 0, i_rst_n, i_wvalid, i_wlast, i_tready;
    logic [7:0] i_wdata;
    logic o_wready, o_tvalid, o_tlast, o_trunc;
    logic [7:0] o_tdata;
    logic [15:0] o_frame_cnt;
    int checks = 0, errors = 0;
    logic [7:0] rx[$];
    int tlast_at[$], gaps[$];
    int stalls = 0, stall_bad = 0, gap_bad = 0, trunc_n = 0, wr_hi = 0, gcnt = 0;
    logic stall = 0, in_gap = 0, sl;
    logic [7:0] sd;
    eth_tx_pad dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .i_wlast(i_wlast),
        .o_wready(o_wready), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
        .o_tlast(o_tlast), .o_trunc(o_trunc), .o_frame_cnt(o_frame_cnt)
    );
    always #5 i_clk = ~i_clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // handshakes are recorded at the falling edge for the rising edge that follows
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            stall  = 0;
            in_gap = 0;
        end else begin
            if (stall) begin
                stalls++;
                if (!o_tvalid || o_tdata !== sd || o_tlast !== sl) stall_bad++;
            end
            if (in_gap) begin
                if (o_wready) begin
                    in_gap = 0;
                    gaps.push_back(gcnt);
                end else begin
                    gcnt++;
                    if (o_tvalid) gap_bad++;
                end
            end
            if (o_trunc) trunc_n++;
            stall = o_tvalid && !i_tready;
            sd = o_tdata;
            sl = o_tlast;
            if (o_tvalid && i_tready) begin
                rx.push_back(o_tdata);
                if (o_tlast) begin
                    tlast_at.push_back(rx.size());
                    in_gap = 1;
                    gcnt = 0;
                end
            end
        end
    end
    task automatic send(input int n, input int base, input bit last);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            logic ok;
            i_wvalid = 1;
            i_wdata  = 8'(base + i);
            i_wlast  = last && i == n - 1;
            do begin
                @(negedge i_clk);
                ok = o_wready;
                @(posedge i_clk); #1;
                t++;
            end while (!ok && t < 5000);
            if (!ok) chk("wr_timeout", 0, 1);
        end
        i_wvalid = 0;
        i_wlast  = 0;
    endtask
    task automatic wait_last(input int k, input bit bp);
        int t = 0;
        while (tlast_at.size() < k && t < 5000) begin
            @(posedge i_clk); #1;
            if (bp) i_tready = 1'($urandom_range(0, 1));
            if (o_wready) wr_hi++;
            t++;
        end
        i_tready = 1;
        if (tlast_at.size() < k) chk("tlast_timeout", tlast_at.size(), k);
    endtask
    task automatic check_frame(input string tag, input int s, input int e, input int n, input int base);
        int len = n < 46 ? 46 : n;
        int bad = 0;
        logic [7:0] exp;
        chk({tag, "_len"}, e - s, len);
        for (int i = 0; i < len; i++) begin
            exp = i < n ? 8'(base + i) : 8'h00;
            if (s + i >= rx.size() || rx[s + i] !== exp) bad++;
        end
        chk({tag, "_data_bad"}, bad, 0);
    endtask
    initial begin
        int s, g0, t;
        i_rst_n = 0; i_wdata = 0; i_wvalid = 0; i_wlast = 0; i_tready = 1;
        #1;
        chk("rst_wready", o_wready, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tlast", o_tlast, 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_trunc", o_trunc, 0);
        chk("rst_cnt", o_frame_cnt, 0);
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1;
        #1 chk("wready_pre_edge", o_wready, 0);
        @(posedge i_clk); #1;
        chk("wready_first_edge", o_wready, 1);
        s = rx.size();
        send(3, 'hA1, 1);
        chk("lat_e0_tvalid", o_tvalid, 0);
        @(posedge i_clk); #1;
        chk("lat_e1_tvalid", o_tvalid, 0);
        @(posedge i_clk); #1;
        chk("lat_e2_tvalid", o_tvalid, 1);
        chk("lat_e2_tdata", o_tdata, 'hA1);
        wait_last(1, 0);
        check_frame("short", s, tlast_at[$], 3, 'hA1);
        chk("short_cnt", o_frame_cnt, 1);
        s = rx.size();
        send(46, 0, 1);
        wait_last(2, 0);
        check_frame("min", s, tlast_at[$], 46, 0);
        s = rx.size();
        send(60, 0, 1);
        wait_last(3, 0);
        check_frame("long", s, tlast_at[$], 60, 0);
        chk("long_cnt", o_frame_cnt, 3);
        s = rx.size();
        send(50, 'h10, 1);
        wait_last(4, 1);
        check_frame("bp", s, tlast_at[$], 50, 'h10);
        chk("bp_stall_bad", stall_bad, 0);
        chk("bp_stalls_seen", stalls > 0, 1);
        s = rx.size();
        send(1024, 0, 0);
        i_wvalid = 1; i_wdata = 8'hEE; i_wlast = 1;
        wr_hi = 0;
        wait_last(5, 0);
        chk("trunc_wready_low", wr_hi, 0);
        repeat (5) @(posedge i_clk);
        #1 i_wvalid = 0; i_wlast = 0;
        repeat (10) @(posedge i_clk);
        #1;
        check_frame("trunc", s, tlast_at[$], 1024, 0);
        chk("trunc_pulses", trunc_n, 1);
        chk("trunc_gap", gaps[$], 12);
        chk("trunc_cnt", o_frame_cnt, 5);
        chk("trunc_no_extra", rx.size(), s + 1024);
        chk("trunc_wready_after", o_wready, 1);
        s = rx.size();
        g0 = gaps.size();
        send(10, 'h60, 1);
        send(10, 'h70, 1);
        wait_last(7, 0);
        repeat (15) @(posedge i_clk);
        #1;
        check_frame("b2b1", s, tlast_at[5], 10, 'h60);
        check_frame("b2b2", tlast_at[5], tlast_at[6], 10, 'h70);
        chk("b2b_gaps", gaps.size() - g0, 2);
        chk("b2b_gap1", gaps[g0], 12);
        chk("b2b_gap2", gaps[g0 + 1], 12);
        chk("b2b_cnt", o_frame_cnt, 7);
        s = rx.size();
        send(10, 'h30, 1);
        t = 0;
        while (rx.size() < s + 20 && t < 500) begin
            @(posedge i_clk); #1;
            t++;
        end
        chk("rst_reach20", rx.size() >= s + 20, 1);
        #3 i_rst_n = 0;
        #1;
        chk("midrst_tvalid", o_tvalid, 0);
        chk("midrst_cnt", o_frame_cnt, 0);
        chk("midrst_wready", o_wready, 0);
        @(posedge i_clk);
        #3 i_rst_n = 1;
        @(posedge i_clk); #1;
        chk("midrst_wready_up", o_wready, 1);
        s = rx.size();
        send(5, 'h50, 1);
        wait_last(8, 0);
        check_frame("post_rst", s, tlast_at[$], 5, 'h50);
        chk("post_rst_cnt", o_frame_cnt, 1);
        chk("gap_tvalid_bad", gap_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
